dcache_wt: RTL
==============

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage and the multi-cycle data RAM.
- Read hits return data the same cycle with no stall.
- Read misses and all writes go out to the RAM using its cs/stall handshake, and the cache stalls the pipeline until the RAM completes.
- One word per line; word addressing throughout.

Parameters:
- INDEX_WIDTH, 3, log2 of line count (8 lines).
- TAG_WIDTH, 32-INDEX_WIDTH, derived; upper address bits stored as tag.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU access valid this cycle.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  word address.
- cpu_din  in  32  store data.
- cpu_dout  out  32  load data.
- cpu_stall  out  1  hold MEM stage; CPU keeps req/we/addr/din stable while high.
- mem_cs  out  1  RAM request.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM word address.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data.
- mem_stall  in  1  RAM busy (cs & ~ack).

Behaviour:
- Storage: valid[2^INDEX_WIDTH], tag[...][TAG_WIDTH], data[...][32].
  - index = cpu_addr[INDEX_WIDTH-1:0]; tag = cpu_addr[31:INDEX_WIDTH].
  - hit = valid[index] & (tag[index]==tag).
- Reset: state=IDLE, all valid=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, first=0. cpu_stall is combinational, so it is 0 when cpu_req=0.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - cpu_req & ~cpu_we & hit: cpu_dout=data[index], cpu_stall=0, no state change.
  - cpu_req & ~cpu_we & ~hit: cpu_stall=1. Next state FILL. Register mem_cs=1, mem_we=0, mem_addr=cpu_addr, first=1.
  - cpu_req & cpu_we: cpu_stall=1. Next state WRITE. Register mem_cs=1, mem_we=1, mem_addr=cpu_addr, mem_din=cpu_din, first=1.
  - ~cpu_req: mem_cs=0, and mem_addr/mem_din hold their last values.
- Issue guard:
  - The cycle after issue (first=1), mem_stall is ignored and first clears. The RAM's ack from the previous address is stale until the RAM sees the new address.
  - Minimum miss/write latency is therefore 2 stall cycles.
- done = (state!=IDLE) & ~first & ~mem_stall.
- FILL:
  - While ~done: cpu_stall=1, and mem_* are held exactly stable.
  - On done: cpu_dout=mem_dout (forwarded) and cpu_stall=0 in the same cycle. At posedge: valid[index]=1, tag/data written, mem_cs=0, state=IDLE.
- WRITE:
  - While ~done: cpu_stall=1, and mem_* are held.
  - On done: cpu_stall=0. If hit, data[index]=mem_din (write-update). On a miss, the line is not allocated and is left untouched. mem_cs=0, mem_we=0, state=IDLE.
- cpu_stall = cpu_req & ~((state==IDLE & ~cpu_we & hit) | done).
- cpu_dout is don't-care (drive data[index]) when not a hit or done-read.
- Conflict: a fill to the same index overwrites the existing line. There is no dirty state (write-through), so no writeback is needed.
- Back-to-back accesses:
  - After done, the CPU advances. The next request is evaluated in IDLE on the following cycle; there is no dead cycle on hits.
  - A new miss may reuse the same mem_addr; the issue guard still applies.
- Reset mid-operation: FILL/WRITE is aborted and the state returns to IDLE with valid cleared. mem_cs deasserts on the next cycle. A partially written RAM location is the RAM's concern.
- cpu_req dropping mid-transaction is illegal; the cache completes the transaction regardless.

Test Plan:
- Cold read miss: after reset, RAM word 5 = 0xDEADBEEF, read addr 5 -> cpu_stall high for ≥2 cycles until RAM ack; done-cycle cpu_dout=0xDEADBEEF; the next read of addr 5 has stall=0 and dout=0xDEADBEEF, with mem_cs held 0.
- Write hit: with line 5 valid, store 0x12345678 to addr 5 -> stall until RAM ack with mem_we=1 and mem_addr=5; a following read of addr 5 hits with 0x12345678 and no mem_cs.
- Write miss, no allocate: store 0xA5A5A5A5 to addr 6 (invalid) -> RAM written; a read of addr 6 then misses, fills, and returns 0xA5A5A5A5.
- Conflict: read 5 (fill), read 13 (same index 5, fill, evicts), read 5 -> misses again and returns the RAM value; mem_addr sequence 5, 13, 5.
- Hold stability: during any FILL/WRITE, mem_addr, mem_we and mem_din must not change until done; this is checked with a per-cycle assertion and an RAM model requiring 7 stable cycles.
- Reset mid-fill: assert rst in the 3rd FILL cycle -> next cycle state IDLE, mem_cs=0, cpu_stall=0 with req low; a read of the previously valid addr misses.

Source files
------------

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Read hits answer combinationally. Read misses and all stores stall the CPU until the RAM acks.
module dcache_wt #(
  parameter int INDEX_WIDTH = 3,
  parameter int TAG_WIDTH   = 32 - INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_stall
);
  // state | meaning
  // IDLE  | no RAM transaction open; hits are served in the same cycle
  // FILL  | read miss open at the RAM; the line is written when the RAM completes
  // WRITE | store open at the RAM; a resident line is updated when the RAM completes
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;
  localparam int LINES = 1 << INDEX_WIDTH;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_first;
  logic [LINES-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [LINES];
  logic [31:0]            r_data [LINES];
  logic                   r_mem_cs;
  logic                   r_mem_we;
  logic [31:0]            r_mem_addr;
  logic [31:0]            r_mem_din;

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_hit;
  logic                   w_done;
  logic                   w_issue;

  assign w_index = cpu_addr[INDEX_WIDTH-1:0];
  assign w_tag   = cpu_addr[31:INDEX_WIDTH];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // The first cycle after issue carries a stale ack for the previous address.
  assign w_done  = (r_state != S_IDLE) && !r_first && !mem_stall;
  assign w_issue = (r_state == S_IDLE) && cpu_req && (cpu_we || !w_hit);

  assign mem_cs   = r_mem_cs;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = cpu_we ? S_WRITE : S_FILL;
      S_FILL,
      S_WRITE: if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = cpu_req && !(((r_state == S_IDLE) && !cpu_we && w_hit) || w_done);
    cpu_dout  = ((r_state == S_FILL) && w_done) ? mem_dout : r_data[w_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_first    <= 1'b0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_first <= w_issue;
      if (w_issue) begin
        r_mem_cs   <= 1'b1;
        r_mem_we   <= cpu_we;
        r_mem_addr <= cpu_addr;
        if (cpu_we) r_mem_din <= cpu_din;
      end else if (w_done) begin
        r_mem_cs <= 1'b0;
        r_mem_we <= 1'b0;
      end
      if (w_done && (r_state == S_FILL)) r_valid[w_index] <= 1'b1;
    end
  end

  // Tag and data need no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!rst && w_done) begin
      if (r_state == S_FILL) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_dout;
      end else if ((r_state == S_WRITE) && w_hit) begin
        r_data[w_index] <= r_mem_din;
      end
    end
  end
endmodule
